// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - hazard control pipeline-side signal bundle
interface hazard_control_unit_if #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH           = 16
);
    logic [6:0]                     opcode_ID;
    logic [REGISTER_ADDR_WIDTH-1:0] rs1_ID;
    logic [REGISTER_ADDR_WIDTH-1:0] rs2_ID;
    logic [6:0]                     opcode_EX;
    logic [REGISTER_ADDR_WIDTH-1:0] rd_EX;
    logic                           redirect_EX;
    logic                           dmem_req_MEM;
    logic                           dmem_ready;

    logic                           stall_PC;
    logic                           stall_IF_ID;
    logic                           stall_ID_EX;
    logic                           stall_EX_MEM;
    logic                           bubble_MEM_WB;
    logic                           flush_IF_ID;
    logic                           flush_ID_EX;
    logic [1:0]                     hazard_state;
    logic                           mem_timeout_err;
    logic [CNT_WIDTH-1:0]           load_use_cnt;
    logic [CNT_WIDTH-1:0]           flush_cnt;
    logic [CNT_WIDTH-1:0]           mem_stall_cnt;

    // Pipeline side: supplies stage information, consumes controls.
    modport master (
        output opcode_ID, rs1_ID, rs2_ID, opcode_EX, rd_EX,
               redirect_EX, dmem_req_MEM, dmem_ready,
        input  stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
               bubble_MEM_WB, flush_IF_ID, flush_ID_EX, hazard_state,
               mem_timeout_err, load_use_cnt, flush_cnt, mem_stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  opcode_ID, rs1_ID, rs2_ID, opcode_EX, rd_EX,
               redirect_EX, dmem_req_MEM, dmem_ready,
        output stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM,
               bubble_MEM_WB, flush_IF_ID, flush_ID_EX, hazard_state,
               mem_timeout_err, load_use_cnt, flush_cnt, mem_stall_cnt
    );
endinterface

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush controller for the five-stage core
module hazard_control_unit #(
    parameter int REGISTER_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT         = 255,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave hz
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_CAL_R  = 7'b0110011;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] wait_q, wait_d;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_WIDTH-1:0] fl_cnt_q, fl_cnt_d;
    logic [CNT_WIDTH-1:0] ms_cnt_q, ms_cnt_d;

    logic [REGISTER_ADDR_WIDTH-1:0] rs1_id, rs2_id, rd_ex;
    logic use_rs1, use_rs2, load_use, mem_busy;
    logic [CNT_WIDTH-1:0] wait_inc;

    logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, bubble_mem_wb;
    logic flush_if_id, flush_id_ex;

    assign rs1_id = hz.rs1_ID;
    assign rs2_id = hz.rs2_ID;
    assign rd_ex  = hz.rd_EX;

    assign use_rs1 = !((hz.opcode_ID == OP_LUI) || (hz.opcode_ID == OP_AUIPC) ||
                       (hz.opcode_ID == OP_JAL));
    assign use_rs2 = (hz.opcode_ID == OP_BRANCH) || (hz.opcode_ID == OP_STORE) ||
                     (hz.opcode_ID == OP_CAL_R);

    assign load_use = (hz.opcode_EX == OP_LOAD) && (rd_ex != '0) &&
                      ((use_rs1 && (rs1_id == rd_ex)) || (use_rs2 && (rs2_id == rd_ex)));
    assign mem_busy = hz.dmem_req_MEM && !hz.dmem_ready;
    assign wait_inc = wait_q + CNT_ONE;

    // Next-state, counter updates and pipeline controls; priority is
    // ERROR, then memory freeze, then redirect, then load-use.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        err_d         = err_q;
        lu_cnt_d      = lu_cnt_q;
        fl_cnt_d      = fl_cnt_q;
        ms_cnt_d      = ms_cnt_q;
        stall_pc      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        stall_ex_mem  = 1'b0;
        bubble_mem_wb = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;

        if (state_q == ST_ERROR) begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            stall_ex_mem  = 1'b1;
            bubble_mem_wb = 1'b1;
        end else if (mem_busy) begin
            // Whole pipe frozen; a redirect held in EX waits for release.
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            stall_ex_mem  = 1'b1;
            bubble_mem_wb = 1'b1;
            if (ms_cnt_q != CNT_MAX) ms_cnt_d = ms_cnt_q + CNT_ONE;
            if (state_q == ST_RUN) begin
                state_d = ST_MEM_WAIT;
                wait_d  = CNT_ONE;
            end else if (wait_inc == TIMEOUT_C) begin
                state_d = ST_ERROR;
                wait_d  = wait_inc;
                err_d   = 1'b1;
            end else begin
                wait_d  = wait_inc;
            end
        end else begin
            // Normal flow, also the release cycle of a memory wait.
            state_d = ST_RUN;
            wait_d  = '0;
            if (hz.redirect_EX) begin
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (fl_cnt_q != CNT_MAX) fl_cnt_d = fl_cnt_q + CNT_ONE;
            end else if (load_use) begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
                if (lu_cnt_q != CNT_MAX) lu_cnt_d = lu_cnt_q + CNT_ONE;
            end
        end
    end

    // State, wait counter, sticky error flag and statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            wait_q   <= '0;
            err_q    <= 1'b0;
            lu_cnt_q <= '0;
            fl_cnt_q <= '0;
            ms_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            err_q    <= err_d;
            lu_cnt_q <= lu_cnt_d;
            fl_cnt_q <= fl_cnt_d;
            ms_cnt_q <= ms_cnt_d;
        end
    end

    assign hz.stall_PC        = stall_pc;
    assign hz.stall_IF_ID     = stall_if_id;
    assign hz.stall_ID_EX     = stall_id_ex;
    assign hz.stall_EX_MEM    = stall_ex_mem;
    assign hz.bubble_MEM_WB   = bubble_mem_wb;
    assign hz.flush_IF_ID     = flush_if_id;
    assign hz.flush_ID_EX     = flush_id_ex;
    assign hz.hazard_state    = state_q;
    assign hz.mem_timeout_err = err_q;
    assign hz.load_use_cnt    = lu_cnt_q;
    assign hz.flush_cnt       = fl_cnt_q;
    assign hz.mem_stall_cnt   = ms_cnt_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_CAL_R = 7'b0110011;
    localparam logic [6:0] OP_CAL_I = 7'b0010011;

    // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, bubble_MEM_WB, flush_IF_ID, flush_ID_EX}
    localparam logic [6:0] C_IDLE   = 7'b0000000;
    localparam logic [6:0] C_LDUSE  = 7'b1100001;
    localparam logic [6:0] C_FREEZE = 7'b1111100;
    localparam logic [6:0] C_FLUSH  = 7'b0000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_control_unit_if #(.REGISTER_ADDR_WIDTH(5), .CNT_WIDTH(16)) hif ();

    hazard_control_unit #(
        .REGISTER_ADDR_WIDTH(5),
        .MEM_TIMEOUT(4),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hz (hif.slave)
    );

    logic [6:0] ctrl;
    assign ctrl = {hif.stall_PC, hif.stall_IF_ID, hif.stall_ID_EX, hif.stall_EX_MEM,
                   hif.bubble_MEM_WB, hif.flush_IF_ID, hif.flush_ID_EX};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [6:0] op_id, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [6:0] op_ex, input logic [4:0] rd,
                          input logic redir, input logic req, input logic rdy);
        hif.opcode_ID    = op_id;
        hif.rs1_ID       = rs1;
        hif.rs2_ID       = rs2;
        hif.opcode_EX    = op_ex;
        hif.rd_EX        = rd;
        hif.redirect_EX  = redir;
        hif.dmem_req_MEM = req;
        hif.dmem_ready   = rdy;
        #4;
    endtask

    initial begin
        set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("reset_state", 32'(hif.hazard_state), 32'd0);
        chk("reset_err", 32'(hif.mem_timeout_err), 32'd0);
        chk("reset_lu_cnt", 32'(hif.load_use_cnt), 32'd0);
        chk("reset_fl_cnt", 32'(hif.flush_cnt), 32'd0);
        chk("reset_ms_cnt", 32'(hif.mem_stall_cnt), 32'd0);
        chk("reset_ctrl", 32'(ctrl), 32'(C_IDLE));
        tick();

        // Load-use on rs1: LOAD x5 in EX, ADD x6,x5,x7 in ID
        set_in(OP_CAL_R, 5'd5, 5'd7, OP_LOAD, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("lu_rs1_ctrl", 32'(ctrl), 32'(C_LDUSE));
        tick();
        chk("lu_rs1_cnt", 32'(hif.load_use_cnt), 32'd1);
        set_in(OP_CAL_R, 5'd5, 5'd7, OP_CAL_I, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_after_ctrl", 32'(ctrl), 32'(C_IDLE));
        tick();

        // Load-use on rs2 of a store
        set_in(OP_STORE, 5'd1, 5'd7, OP_LOAD, 5'd7, 1'b0, 1'b0, 1'b0);
        chk("lu_rs2_ctrl", 32'(ctrl), 32'(C_LDUSE));
        tick();
        chk("lu_rs2_cnt", 32'(hif.load_use_cnt), 32'd2);

        // No false hazards
        set_in(OP_CAL_R, 5'd0, 5'd0, OP_LOAD, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("nofalse_x0", 32'(ctrl), 32'(C_IDLE));
        tick();
        set_in(OP_LUI, 5'd5, 5'd5, OP_LOAD, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("nofalse_lui", 32'(ctrl), 32'(C_IDLE));
        tick();
        set_in(OP_CAL_I, 5'd1, 5'd5, OP_LOAD, 5'd5, 1'b0, 1'b0, 1'b0);
        chk("nofalse_cali_rs2", 32'(ctrl), 32'(C_IDLE));
        tick();
        chk("nofalse_cnt", 32'(hif.load_use_cnt), 32'd2);

        // Redirect beats load-use
        set_in(OP_CAL_R, 5'd5, 5'd7, OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("redir_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        chk("redir_fl_cnt", 32'(hif.flush_cnt), 32'd1);
        chk("redir_lu_cnt", 32'(hif.load_use_cnt), 32'd2);

        // Memory wait: 3 busy cycles then ready
        for (int i = 0; i < 3; i++) begin
            set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("mw_ctrl_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            chk($sformatf("mw_state_%0d", i), 32'(hif.hazard_state), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b0, 1'b1, 1'b1);
        chk("mw_release_ctrl", 32'(ctrl), 32'(C_IDLE));
        chk("mw_release_state", 32'(hif.hazard_state), 32'd1);
        tick();
        chk("mw_after_state", 32'(hif.hazard_state), 32'd0);
        chk("mw_ms_cnt", 32'(hif.mem_stall_cnt), 32'd3);

        // Redirect held during a 2-cycle freeze
        for (int i = 0; i < 2; i++) begin
            set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("rf_ctrl_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            tick();
        end
        chk("rf_fl_cnt_frozen", 32'(hif.flush_cnt), 32'd1);
        set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b1, 1'b1, 1'b1);
        chk("rf_release_ctrl", 32'(ctrl), 32'(C_FLUSH));
        tick();
        chk("rf_fl_cnt", 32'(hif.flush_cnt), 32'd2);
        chk("rf_ms_cnt", 32'(hif.mem_stall_cnt), 32'd5);
        set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rf_idle_ctrl", 32'(ctrl), 32'(C_IDLE));
        tick();

        // Timeout: ready never arrives, MEM_TIMEOUT=4
        for (int i = 0; i < 4; i++) begin
            set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("to_ctrl_%0d", i), 32'(ctrl), 32'(C_FREEZE));
            chk($sformatf("to_err_%0d", i), 32'(hif.mem_timeout_err), 32'd0);
            tick();
        end
        chk("to_state", 32'(hif.hazard_state), 32'd2);
        chk("to_err", 32'(hif.mem_timeout_err), 32'd1);
        chk("to_ms_cnt", 32'(hif.mem_stall_cnt), 32'd9);
        set_in(OP_CAL_R, 5'd5, 5'd7, OP_LOAD, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("err_stuck_ctrl", 32'(ctrl[6:3]), 32'hF);
        chk("err_no_flush", 32'(ctrl[1:0]), 32'd0);
        tick();
        chk("err_hold_state", 32'(hif.hazard_state), 32'd2);
        chk("err_frozen_fl", 32'(hif.flush_cnt), 32'd2);
        chk("err_frozen_lu", 32'(hif.load_use_cnt), 32'd2);

        // Reset out of ERROR
        set_in(OP_CAL_I, 5'd0, 5'd0, OP_CAL_I, 5'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_state", 32'(hif.hazard_state), 32'd0);
        chk("rst2_err", 32'(hif.mem_timeout_err), 32'd0);
        chk("rst2_lu", 32'(hif.load_use_cnt), 32'd0);
        chk("rst2_fl", 32'(hif.flush_cnt), 32'd0);
        chk("rst2_ms", 32'(hif.mem_stall_cnt), 32'd0);
        chk("rst2_ctrl", 32'(ctrl), 32'(C_IDLE));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline stall/flush controller for the five-stage core.
- Companion to the forwarding detector: it handles every hazard that forwarding cannot resolve.
  - Load-use: one bubble is inserted.
  - Taken branch/jump in EX: the younger instructions are flushed.
  - Data-memory wait states: the whole pipe is frozen while the MEM access is in flight.
- Drives the stall/flush/bubble controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. Also keeps hazard statistics and a memory-timeout error flag.

Parameters:
- REGISTER_ADDR_WIDTH, 5, register index width.
- MEM_TIMEOUT, 255, max consecutive MEM wait cycles before error; must fit in CNT_WIDTH.
- CNT_WIDTH, 16, width of the wait counter and the statistics counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- opcode_ID  input  7  opcode in ID
- rs1_ID  input  REGISTER_ADDR_WIDTH  rs1 in ID
- rs2_ID  input  REGISTER_ADDR_WIDTH  rs2 in ID
- opcode_EX  input  7  opcode in EX
- rd_EX  input  REGISTER_ADDR_WIDTH  rd in EX
- redirect_EX  input  1  taken branch, JAL or JALR resolved in EX
- dmem_req_MEM  input  1  MEM stage holds a load/store
- dmem_ready  input  1  data memory completes the access this cycle
- stall_PC  output  1  hold the PC
- stall_IF_ID  output  1  hold the IF/ID register
- stall_ID_EX  output  1  hold the ID/EX register
- stall_EX_MEM  output  1  hold the EX/MEM register
- bubble_MEM_WB  output  1  write a NOP into MEM/WB
- flush_IF_ID  output  1  clear the IF/ID register
- flush_ID_EX  output  1  clear the ID/EX register (bubble insert)
- hazard_state  output  2  0 RUN, 1 MEM_WAIT, 2 ERROR
- mem_timeout_err  output  1  sticky timeout flag
- load_use_cnt  output  CNT_WIDTH  count of load-use bubbles
- flush_cnt  output  CNT_WIDTH  count of redirect flushes
- mem_stall_cnt  output  CNT_WIDTH  count of cycles spent frozen on memory

Behaviour:
- Reset (rst=1 at a clk edge): state=RUN, wait counter=0, mem_timeout_err=0, all three statistics counters=0. Control outputs are combinational and read 0 while state=RUN and inputs are idle.
- Source-use decode (opcode macros from riscv_defs.vh):
  - ID_use_rs1 = opcode_ID not in {LUI, AUIPC, JAL}.
  - ID_use_rs2 = opcode_ID in {BRANCH, STORE, CAL_R}.
- load_use = (opcode_EX == LOAD) && rd_EX != 0 && ((ID_use_rs1 && rs1_ID == rd_EX) || (ID_use_rs2 && rs2_ID == rd_EX)).
- mem_busy = dmem_req_MEM && !dmem_ready.
- Priority, highest first: ERROR > mem_busy > redirect_EX > load_use.
- RUN state:
  - mem_busy: assert stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM and bubble_MEM_WB; drive no flushes. Next state is MEM_WAIT and the wait counter is set to 1.
  - Otherwise redirect_EX: assert flush_IF_ID and flush_ID_EX for one cycle with no stalls. flush_cnt increments. A simultaneous load_use is ignored because the ID instruction is being squashed.
  - Otherwise load_use: assert stall_PC, stall_IF_ID and flush_ID_EX. load_use_cnt increments. Exactly one bubble is inserted: the next cycle the load is in MEM, load_use deasserts, and WB->EX forwarding supplies the data.
- MEM_WAIT state:
  - The four stalls and bubble_MEM_WB stay asserted while mem_busy. mem_stall_cnt increments every frozen cycle (RUN entry cycle included). The wait counter increments.
  - When dmem_ready=1: no stall that cycle (the access completes and the pipe advances) and the next state is RUN. Redirect and load-use are evaluated in that same cycle exactly as in RUN.
  - When the wait counter == MEM_TIMEOUT and still busy: next state is ERROR and mem_timeout_err is set.
  - A redirect_EX held in a frozen EX stage is not acted on until the release cycle. It is never lost, because EX is held.
- ERROR state: all four stalls asserted permanently, no flushes, counters frozen. Exit only via rst.
- All statistics counters saturate at all-ones; they never wrap.
- rst during MEM_WAIT or ERROR: the next cycle is RUN, with all counters and flags cleared.

Test Plan:
- Load-use: LOAD x5 in EX, then ADD x6,x5,x7 (CAL_R) in ID -> exactly one cycle of stall_PC=stall_IF_ID=flush_ID_EX=1; load_use_cnt=1; next cycle all controls 0.
- No false hazard: LOAD x0 in EX with ID using x0, and separately LOAD x5 in EX with ID=LUI x5 -> no stall; load_use_cnt=0.
- Redirect beats load-use: redirect_EX=1 together with load_use=1 -> flush_IF_ID=flush_ID_EX=1, stall_PC=0; flush_cnt=1, load_use_cnt=0.
- Memory wait: dmem_req_MEM=1, dmem_ready=0 for 3 cycles, then ready=1 -> stalls plus bubble_MEM_WB for 3 cycles, hazard_state=1, released on the ready cycle; mem_stall_cnt=3.
- Redirect during freeze: redirect_EX=1 throughout a 2-cycle memory wait -> no flush during the freeze; a single flush on the release cycle; flush_cnt=1.
- Timeout and reset: MEM_TIMEOUT=4 and ready never arrives -> ERROR after the 4th wait cycle, mem_timeout_err=1, stalls stuck at 1; then rst=1 for one cycle -> RUN, all flags and counters 0.
